// File: rtl/sr_mcycle_pkg.sv
// Types shared by the multi-cycle control FSM and its instruction decoder.
package sr_mcycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    IC_ILLEGAL = 3'd0,
    IC_RTYPE   = 3'd1,
    IC_ADDI    = 3'd2,
    IC_LUI     = 3'd3,
    IC_BEQ     = 3'd4,
    IC_BNE     = 3'd5
  } iclass_t;

  typedef struct packed {
    iclass_t    iclass;
    logic [2:0] alu_control;
    logic       alu_src;
    logic       wd_src;
  } decode_t;

  function automatic logic is_branch(input iclass_t ic);
    return (ic == IC_BEQ) || (ic == IC_BNE);
  endfunction

endpackage

// File: rtl/sr_cpu.svh
// Shared schoolRISCV constants: ALU operation codes and the opcode/funct fields
// recognised by the single-cycle and multi-cycle control units.
`ifndef SR_CPU_SVH
`define SR_CPU_SVH

`define ALU_ADD   3'b000
`define ALU_OR    3'b001
`define ALU_SRL   3'b010
`define ALU_SLTU  3'b011
`define ALU_SUB   3'b100

`define RVOP_ADDI 7'b0010011
`define RVOP_BEQ  7'b1100011
`define RVOP_LUI  7'b0110111
`define RVOP_BNE  7'b1100011
`define RVOP_ADD  7'b0110011
`define RVOP_OR   7'b0110011
`define RVOP_SRL  7'b0110011
`define RVOP_SLTU 7'b0110011
`define RVOP_SUB  7'b0110011

`define RVF3_ADDI 3'b000
`define RVF3_BEQ  3'b000
`define RVF3_BNE  3'b001
`define RVF3_ADD  3'b000
`define RVF3_OR   3'b110
`define RVF3_SRL  3'b101
`define RVF3_SLTU 3'b011
`define RVF3_SUB  3'b000

`define RVF7_ADD  7'b0000000
`define RVF7_OR   7'b0000000
`define RVF7_SRL  7'b0000000
`define RVF7_SLTU 7'b0000000
`define RVF7_SUB  7'b0100000

`endif

// File: rtl/sr_mcycle_decode.sv
// Combinational instruction classifier: exact opcode/funct matching against the
// single-cycle control table, producing the datapath controls for the IR.
`include "sr_cpu.svh"

module sr_mcycle_decode
  import sr_mcycle_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  output decode_t    dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path can infer a latch.
    dec.iclass      = IC_ILLEGAL;
    dec.alu_control = `ALU_ADD;
    dec.alu_src     = 1'b0;
    dec.wd_src      = 1'b0;

    case (op)
      `RVOP_ADD: begin
        if (f7 == `RVF7_ADD) begin
          case (f3)
            `RVF3_ADD: begin
              dec.iclass      = IC_RTYPE;
              dec.alu_control = `ALU_ADD;
            end
            `RVF3_OR: begin
              dec.iclass      = IC_RTYPE;
              dec.alu_control = `ALU_OR;
            end
            `RVF3_SRL: begin
              dec.iclass      = IC_RTYPE;
              dec.alu_control = `ALU_SRL;
            end
            `RVF3_SLTU: begin
              dec.iclass      = IC_RTYPE;
              dec.alu_control = `ALU_SLTU;
            end
            default: ;
          endcase
        end else if (f7 == `RVF7_SUB && f3 == `RVF3_SUB) begin
          dec.iclass      = IC_RTYPE;
          dec.alu_control = `ALU_SUB;
        end
      end

      `RVOP_ADDI: begin
        if (f3 == `RVF3_ADDI) begin
          dec.iclass  = IC_ADDI;
          dec.alu_src = 1'b1;
        end
      end

      `RVOP_LUI: begin
        dec.iclass = IC_LUI;
        dec.wd_src = 1'b1;
      end

      // beq and bne share one opcode; funct3 tells them apart.
      `RVOP_BEQ: begin
        if (f3 == `RVF3_BEQ) begin
          dec.iclass      = IC_BEQ;
          dec.alu_control = `ALU_SUB;
        end else if (f3 == `RVF3_BNE) begin
          dec.iclass      = IC_BNE;
          dec.alu_control = `ALU_SUB;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/sr_mcycle_control.sv
// Multi-cycle RISC-V control unit: FETCH/DECODE/EXEC/WB/TRAP sequencer with a
// retired-instruction counter. Strobes are decoded from the state register.
`include "sr_cpu.svh"

module sr_mcycle_control
  import sr_mcycle_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imemReq,
  input  logic                 imemAck,
  input  logic [6:0]           cmdOp,
  input  logic [2:0]           cmdF3,
  input  logic [6:0]           cmdF7,
  input  logic                 aluZero,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic                 pcSrc,
  output logic                 regWrite,
  output logic                 aluSrc,
  output logic                 wdSrc,
  output logic [2:0]           aluControl,
  output logic                 trap,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  state_t                 state_q;
  logic                   trap_q;
  logic [INSTRET_W-1:0]   instret_q;
  decode_t                dec;

  sr_mcycle_decode u_decode (
    .op  (cmdOp),
    .f3  (cmdF3),
    .f7  (cmdF7),
    .dec (dec)
  );

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imemAck) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          if (dec.iclass == IC_ILLEGAL) begin
            state_q <= ST_TRAP;
            trap_q  <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_branch(dec.iclass)) begin
            instret_q <= instret_q + INSTRET_W'(1);
            state_q   <= ST_FETCH;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          instret_q <= instret_q + INSTRET_W'(1);
          state_q   <= ST_FETCH;
        end
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Reset is visible on the outputs in the same cycle it is asserted, so an
  // instruction caught mid-flight never produces a late write strobe.
  always_comb begin
    imemReq    = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    regWrite   = 1'b0;
    aluControl = `ALU_ADD;
    aluSrc     = 1'b0;
    wdSrc      = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          imemReq = 1'b1;
          irWrite = imemAck;
        end
        ST_DECODE, ST_EXEC, ST_WB: begin
          aluControl = dec.alu_control;
          aluSrc     = dec.alu_src;
          wdSrc      = dec.wd_src;
          if (state_q == ST_EXEC && is_branch(dec.iclass)) begin
            pcWrite = 1'b1;
            pcSrc   = (dec.iclass == IC_BEQ) ? aluZero : !aluZero;
          end
          if (state_q == ST_WB) begin
            regWrite = 1'b1;
            pcWrite  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state   = rst ? ST_FETCH : state_q;
  assign trap    = !rst && trap_q;
  assign instret = rst ? '0 : instret_q;

endmodule

// File: tb/tb_sr_mcycle_control.sv
// Scoreboard bench for sr_mcycle_control: a behavioural model predicts every
// output each cycle; predictions are queued at drive time and compared later.
module tb_sr_mcycle_control;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, imemAck, aluZero;
  logic [6:0]    cmdOp, cmdF7;
  logic [2:0]    cmdF3;
  logic          imemReq, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, trap;
  logic [2:0]    aluControl, state;
  logic [IW-1:0] instret;

  sr_mcycle_control #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .imemReq(imemReq), .imemAck(imemAck),
    .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7), .aluZero(aluZero),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
    .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl), .trap(trap),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_OR   = 32'h003160B3;
  localparam logic [31:0] I_SRL  = 32'h003150B3;
  localparam logic [31:0] I_SLTU = 32'h003130B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;

  typedef enum {K_ILL, K_R, K_ADDI, K_LUI, K_BEQ, K_BNE} kind_e;

  typedef struct {
    logic       imem_req, ir_write, pc_write, pc_src, reg_write, alu_src, wd_src, trap;
    logic [2:0] alu_control, state;
    logic [3:0] instret;
    logic       chk_alu;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // model state: 0 FETCH, 1 DECODE, 2 EXEC, 3 WB, 4 TRAP
  int   m_state = 0;
  bit   m_trap = 0;
  int   m_instret = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL c%0d %s: got %0h expected %0h", cyc, tag, got, exp);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] ir);
    logic [31:0] r_bits, i_bits, o_bits;
    r_bits = ir & 32'hFE00707F;
    i_bits = ir & 32'h0000707F;
    o_bits = ir & 32'h0000007F;
    if (r_bits inside {32'h00000033, 32'h00006033, 32'h00005033, 32'h00003033, 32'h40000033})
      return K_R;
    if (i_bits == 32'h00000013) return K_ADDI;
    if (o_bits == 32'h00000037) return K_LUI;
    if (i_bits == 32'h00000063) return K_BEQ;
    if (i_bits == 32'h00001063) return K_BNE;
    return K_ILL;
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] ir);
    kind_e k;
    k = kind_of(ir);
    if (k == K_BEQ || k == K_BNE) return 3'd4;
    case (ir & 32'hFE00707F)
      32'h00006033: return 3'd1;
      32'h00005033: return 3'd2;
      32'h00003033: return 3'd3;
      32'h40000033: return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic exp_t predict(input logic r, input logic ack, input logic zero,
                                   input logic [31:0] ir);
    exp_t  e;
    kind_e k;
    k = kind_of(ir);
    e = '{default: 1'b0, alu_control: 3'd0, state: 3'd0, instret: 4'd0};
    e.chk_alu = 1'b1;
    if (!r) begin
      e.state   = 3'(m_state);
      e.trap    = m_trap;
      e.instret = 4'(m_instret);
      e.chk_alu = (m_state != 4);
      if (m_state == 0) begin
        e.imem_req = 1'b1;
        e.ir_write = ack;
      end
      if (m_state >= 1 && m_state <= 3) begin
        e.alu_control = alu_of(ir);
        e.alu_src     = (k == K_ADDI);
        e.wd_src      = (k == K_LUI);
      end
      if (m_state == 2 && k == K_BEQ) begin
        e.pc_write = 1'b1;
        e.pc_src   = zero;
      end
      if (m_state == 2 && k == K_BNE) begin
        e.pc_write = 1'b1;
        e.pc_src   = !zero;
      end
      if (m_state == 3) begin
        e.pc_write  = 1'b1;
        e.reg_write = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic advance(input logic r, input logic ack, input logic [31:0] ir);
    kind_e k;
    k = kind_of(ir);
    if (r) begin
      m_state = 0; m_trap = 0; m_instret = 0;
    end else begin
      case (m_state)
        0: if (ack) m_state = 1;
        1: if (k == K_ILL) begin m_state = 4; m_trap = 1; end else m_state = 2;
        2: if (k == K_BEQ || k == K_BNE) begin
             m_instret = (m_instret + 1) % 16; m_state = 0;
           end else m_state = 3;
        3: begin m_instret = (m_instret + 1) % 16; m_state = 0; end
        default: ;
      endcase
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic r, input logic ack, input logic zero, input logic [31:0] ir);
    exp_t e;
    rst = r; imemAck = ack; aluZero = zero;
    cmdOp = ir[6:0]; cmdF3 = ir[14:12]; cmdF7 = ir[31:25];
    sb.push_back(predict(r, ack, zero, ir));
    #2;
    e = sb.pop_front();
    check("state",    32'(state),    32'(e.state));
    check("imemReq",  32'(imemReq),  32'(e.imem_req));
    check("irWrite",  32'(irWrite),  32'(e.ir_write));
    check("pcWrite",  32'(pcWrite),  32'(e.pc_write));
    check("regWrite", 32'(regWrite), 32'(e.reg_write));
    if (e.pc_write) check("pcSrc", 32'(pcSrc), 32'(e.pc_src));
    check("trap",     32'(trap),     32'(e.trap));
    check("instret",  32'(instret),  32'(e.instret));
    if (e.chk_alu) begin
      check("aluControl", 32'(aluControl), 32'(e.alu_control));
      check("aluSrc",     32'(aluSrc),     32'(e.alu_src));
      check("wdSrc",      32'(wdSrc),      32'(e.wd_src));
    end
    @(posedge clk);
    advance(r, ack, ir);
    cyc++;
    @(negedge clk);
  endtask

  // later_ack: 0 = low, 1 = high, 2 = random while the instruction runs
  task automatic run(input logic [31:0] ir, input logic zero, input int waits, input int later_ack);
    int   guard;
    logic a;
    for (int i = 0; i < waits; i++) cycle(1'b0, 1'b0, zero, ir);
    cycle(1'b0, 1'b1, zero, ir);
    guard = 0;
    while (m_state != 0 && m_state != 4 && guard < 8) begin
      a = (later_ack == 2) ? 1'($urandom_range(0, 1)) : 1'(later_ack);
      cycle(1'b0, a, zero, ir);
      guard++;
    end
    check("run_bound", 32'(guard < 8), 32'd1);
  endtask

  logic [31:0] alu_list [7] = '{I_ADD, I_OR, I_SRL, I_SLTU, I_SUB, I_ADDI, I_LUI};
  logic [31:0] bad_list [4] = '{32'h00000000, 32'h023100B3, 32'h0020A463, 32'h00109093};

  initial begin
    rst = 1'b1; imemAck = 1'b0; aluZero = 1'b0;
    cmdOp = '0; cmdF3 = '0; cmdF7 = '0;
    @(negedge clk);

    repeat (3) cycle(1'b1, 1'b1, 1'b1, I_ADD);

    run(I_ADD, 1'b0, 0, 0);
    run(I_BEQ, 1'b1, 0, 0);
    run(I_BNE, 1'b1, 0, 0);
    run(I_BEQ, 1'b0, 0, 1);
    run(I_BNE, 1'b0, 0, 1);
    foreach (alu_list[i]) run(alu_list[i], 1'($urandom_range(0, 1)), $urandom_range(0, 2), 2);

    // Slow memory, then an ack that stays high through EXEC and WB.
    run(I_ADDI, 1'b0, 5, 1);

    // Reset landing in WB abandons the add.
    cycle(1'b0, 1'b1, 1'b0, I_ADD);
    cycle(1'b0, 1'b0, 1'b0, I_ADD);
    cycle(1'b0, 1'b0, 1'b0, I_ADD);
    cycle(1'b1, 1'b0, 1'b0, I_ADD);
    cycle(1'b0, 1'b0, 1'b0, I_ADD);

    foreach (bad_list[i]) begin
      run(bad_list[i], 1'b0, 0, 0);
      for (int j = 0; j < 10; j++) cycle(1'b0, 1'(j % 2), 1'(j / 2 % 2), bad_list[i]);
      cycle(1'b1, 1'b0, 1'b0, bad_list[i]);
      cycle(1'b0, 1'b0, 1'b0, I_ADD);
    end

    cycle(1'b1, 1'b0, 1'b0, I_ADDI);
    for (int i = 0; i < 16; i++) run(I_ADDI, 1'b0, $urandom_range(0, 2), 2);
    cycle(1'b0, 1'b0, 1'b0, I_ADDI);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
